// File: rtl/fork_join_ctrl_pkg.sv
// Shared types and helpers for the fork/join controller.
package fork_join_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2
  } join_mode_e;

  typedef enum logic [1:0] {
    FJ_IDLE  = 2'd0,
    FJ_RUN   = 2'd1,
    FJ_DRAIN = 2'd2
  } fj_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fork_join_ctrl_if.sv
// Sequencer/worker-side bundle of the fork/join controller.
interface fork_join_ctrl_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int ID_W  = fork_join_pkg::id_width(N_CH)
) ();
  import fork_join_pkg::*;

  logic              start;
  logic [MODE_W-1:0] mode;
  logic [N_CH-1:0]   ch_en;
  logic              kill_on_join;
  logic [N_CH-1:0]   ch_done;
  logic [N_CH-1:0]   ch_go;
  logic [N_CH-1:0]   ch_kill;
  logic              busy;
  logic              join_done;
  logic              drain_done;
  logic [ID_W-1:0]   first_id;
  logic [N_CH-1:0]   done_mask;
  logic [CNT_W-1:0]  elapsed;

  modport master (
    output start, mode, ch_en, kill_on_join, ch_done,
    input  ch_go, ch_kill, busy, join_done, drain_done, first_id, done_mask, elapsed
  );

  modport slave (
    input  start, mode, ch_en, kill_on_join, ch_done,
    output ch_go, ch_kill, busy, join_done, drain_done, first_id, done_mask, elapsed
  );

endinterface

// File: rtl/fork_join_ctrl_fj_channel.sv
// Per-channel go/done tracking; a completion in the kill cycle wins over the kill.
module fj_channel
  import fork_join_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_launch,
  input  logic i_en,
  input  logic i_done,
  input  logic i_kill,
  output logic o_go,
  output logic o_done,
  output logic o_kill,
  output logic o_hon
);

  logic r_go;
  logic r_done;
  logic w_hon;

  assign w_hon = r_go & i_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_go   <= 1'b0;
      r_done <= 1'b0;
    end else if (i_launch) begin
      r_go   <= i_en;
      r_done <= 1'b0;
    end else if (w_hon) begin
      r_go   <= 1'b0;
      r_done <= 1'b1;
    end else if (i_kill) begin
      r_go   <= 1'b0;
    end
  end

  assign o_go   = r_go;
  assign o_done = r_done;
  assign o_hon  = w_hon;
  assign o_kill = i_kill & r_go & ~i_done;

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join controller: launches worker channels, reports join per mode, drains or kills stragglers.
module fork_join_ctrl #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int ID_W  = fork_join_pkg::id_width(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  fork_join_ctrl_if.slave bus
);
  import fork_join_pkg::*;

  localparam logic [CNT_W-1:0] ELAPSED_MAX = '1;

  fj_state_e         r_state;
  fj_state_e         w_state_nxt;
  logic [MODE_W-1:0] r_mode;
  logic [N_CH-1:0]   r_ch_en;
  logic              r_kill_on_join;
  logic [N_CH-1:0]   w_go;
  logic [N_CH-1:0]   w_done;
  logic [N_CH-1:0]   w_kill;
  logic [N_CH-1:0]   w_hon;
  logic              w_launch;
  logic              w_join;
  logic              w_drain;
  logic              w_kill_req;
  logic              w_mask_full;
  logic [ID_W-1:0]   w_first_idx;
  logic [ID_W-1:0]   r_first_id;
  logic              r_first_seen;
  logic [CNT_W-1:0]  r_elapsed;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    fj_channel u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_launch (w_launch),
      .i_en     (bus.ch_en[gi]),
      .i_done   (bus.ch_done[gi]),
      .i_kill   (w_kill_req),
      .o_go     (w_go[gi]),
      .o_done   (w_done[gi]),
      .o_kill   (w_kill[gi]),
      .o_hon    (w_hon[gi])
    );
  end

  assign w_mask_full = (w_done == r_ch_en);

  always_ff @(posedge clk) begin
    if (rst) r_state <= FJ_IDLE;
    else     r_state <= w_state_nxt;
  end

  // state    | meaning
  // FJ_IDLE  | waiting for start, no channel running
  // FJ_RUN   | channels launched, join condition not yet met
  // FJ_DRAIN | joined, waiting for remaining launched channels to finish
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_join      = 1'b0;
    w_drain     = 1'b0;
    w_kill_req  = 1'b0;
    case (r_state)
      FJ_IDLE: begin
        if (bus.start) begin
          w_launch    = 1'b1;
          w_state_nxt = FJ_RUN;
        end
      end
      FJ_RUN: begin
        if (r_ch_en == '0) begin
          w_join      = 1'b1;
          w_drain     = 1'b1;
          w_state_nxt = FJ_IDLE;
        end else begin
          case (r_mode)
            JOIN_ANY: begin
              if (|w_done) begin
                w_join = 1'b1;
                if (r_kill_on_join) begin
                  w_kill_req  = 1'b1;
                  w_drain     = 1'b1;
                  w_state_nxt = FJ_IDLE;
                end else begin
                  w_state_nxt = FJ_DRAIN;
                end
              end
            end
            JOIN_NONE: begin
              w_join      = 1'b1;
              w_state_nxt = FJ_DRAIN;
            end
            default: begin
              if (w_mask_full) begin
                w_join      = 1'b1;
                w_drain     = 1'b1;
                w_state_nxt = FJ_IDLE;
              end
            end
          endcase
        end
      end
      FJ_DRAIN: begin
        if (w_mask_full) begin
          w_drain     = 1'b1;
          w_state_nxt = FJ_IDLE;
        end
      end
      default: w_state_nxt = FJ_IDLE;
    endcase
    // A reset cycle must never emit a launch, join, drain or kill.
    if (rst) begin
      w_launch    = 1'b0;
      w_join      = 1'b0;
      w_drain     = 1'b0;
      w_kill_req  = 1'b0;
      w_state_nxt = FJ_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode         <= '0;
      r_ch_en        <= '0;
      r_kill_on_join <= 1'b0;
    end else if (w_launch) begin
      r_mode         <= bus.mode;
      r_ch_en        <= bus.ch_en;
      r_kill_on_join <= bus.kill_on_join;
    end
  end

  always_comb begin
    w_first_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_hon[i]) w_first_idx = ID_W'(i);
    end
  end

  // elapsed stops counting on the join cycle itself and stays frozen until the next launch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_elapsed    <= '0;
      r_first_id   <= '0;
      r_first_seen <= 1'b0;
    end else if (w_launch) begin
      r_elapsed    <= '0;
      r_first_id   <= '0;
      r_first_seen <= 1'b0;
    end else begin
      if (r_state == FJ_RUN && !w_join && r_elapsed != ELAPSED_MAX) begin
        r_elapsed <= r_elapsed + 1'b1;
      end
      if (!r_first_seen && |w_hon) begin
        r_first_id   <= w_first_idx;
        r_first_seen <= 1'b1;
      end
    end
  end

  assign bus.ch_go      = rst ? '0 : w_go;
  assign bus.ch_kill    = w_kill;
  assign bus.busy       = (r_state != FJ_IDLE);
  assign bus.join_done  = w_join;
  assign bus.drain_done = w_drain;
  assign bus.first_id   = r_first_id;
  assign bus.done_mask  = w_done;
  assign bus.elapsed    = r_elapsed;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Directed bench for fork_join_ctrl; cycle numbers are relative to the start cycle of each run.
module tb_fork_join_ctrl;
  import fork_join_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fork_join_ctrl_if #(.N_CH(N_CH), .CNT_W(CNT_W), .ID_W(ID_W)) bus ();

  fork_join_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int          o_jc, o_dc, o_bl, o_go0l, o_njoin, o_ndrain, o_nkill;
  logic [3:0]  o_kv, o_fm;
  logic [1:0]  o_fid;
  logic [15:0] o_el, o_fe;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Cycle 0 issues start; d* = cycle of each ch_done pulse (-1 = none); rs_c = stray start while busy.
  task automatic run_case(input logic [1:0] m, input logic [3:0] en, input logic kj,
                          input int d0, input int d1, input int d2, input int d3, input int rs_c);
    int d[4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    o_jc = -1; o_dc = -1; o_bl = -1; o_go0l = -1;
    o_njoin = 0; o_ndrain = 0; o_nkill = 0;
    o_kv = '0; o_fid = '0; o_el = '0;
    for (int c = 0; c <= 40; c++) begin
      bus.start        = (c == 0) || (c == rs_c);
      bus.mode         = (c == 0) ? m  : JOIN_NONE;
      bus.ch_en        = (c == 0) ? en : 4'b1111;
      bus.kill_on_join = (c == 0) ? kj : 1'b1;
      for (int i = 0; i < 4; i++) bus.ch_done[i] = (d[i] == c);
      #1;
      if (c > 0) begin
        if (bus.join_done) begin
          o_njoin++;
          if (o_jc < 0) begin
            o_jc  = c;
            o_fid = bus.first_id;
            o_el  = bus.elapsed;
          end
        end
        if (bus.drain_done) begin
          o_ndrain++;
          if (o_dc < 0) o_dc = c;
        end
        if (bus.ch_kill != '0) begin
          o_nkill++;
          o_kv = o_kv | bus.ch_kill;
        end
        if (!bus.busy && o_bl < 0) o_bl = c;
        if (!bus.ch_go[0] && o_go0l < 0) o_go0l = c;
      end
      @(posedge clk); #1;
    end
    bus.start   = 1'b0;
    bus.ch_done = '0;
    o_fm = bus.done_mask;
    o_fe = bus.elapsed;
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.mode         = '0;
    bus.ch_en        = '0;
    bus.kill_on_join = 1'b0;
    bus.ch_done      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_busy",  32'(bus.busy),      0);
    check_eq("rst_go",    32'(bus.ch_go),     0);
    check_eq("rst_join",  32'(bus.join_done), 0);
    check_eq("rst_mask",  32'(bus.done_mask), 0);
    check_eq("rst_elap",  32'(bus.elapsed),   0);
    check_eq("rst_fid",   32'(bus.first_id),  0);

    run_case(JOIN_ALL, 4'b0111, 1'b0, 20, 30, 10, -1, -1);
    check_eq("all_join_cyc",  o_jc, 31);
    check_eq("all_drain_cyc", o_dc, 31);
    check_eq("all_fid",       32'(o_fid), 2);
    check_eq("all_elapsed",   32'(o_el), 30);
    check_eq("all_busy_low",  o_bl, 32);
    check_eq("all_njoin",     o_njoin, 1);
    check_eq("all_nkill",     o_nkill, 0);
    check_eq("all_mask",      32'(o_fm), 4'b0111);
    check_eq("all_el_hold",   32'(o_fe), 30);

    run_case(JOIN_ANY, 4'b0111, 1'b0, 20, 30, 10, -1, -1);
    check_eq("any_join_cyc",  o_jc, 11);
    check_eq("any_fid",       32'(o_fid), 2);
    check_eq("any_elapsed",   32'(o_el), 10);
    check_eq("any_go0_low",   o_go0l, 21);
    check_eq("any_drain_cyc", o_dc, 31);
    check_eq("any_ndrain",    o_ndrain, 1);
    check_eq("any_busy_low",  o_bl, 32);
    check_eq("any_nkill",     o_nkill, 0);
    check_eq("any_el_hold",   32'(o_fe), 10);

    run_case(JOIN_ANY, 4'b0111, 1'b1, 20, 30, 10, -1, -1);
    check_eq("kill_join_cyc",  o_jc, 11);
    check_eq("kill_mask_out",  32'(o_kv), 4'b0011);
    check_eq("kill_npulse",    o_nkill, 1);
    check_eq("kill_drain_cyc", o_dc, 11);
    check_eq("kill_busy_low",  o_bl, 12);
    check_eq("kill_go0_low",   o_go0l, 12);
    check_eq("kill_done_mask", 32'(o_fm), 4'b0100);

    run_case(JOIN_ALL, 4'b0000, 1'b0, -1, -1, -1, -1, -1);
    check_eq("en0_join_cyc",  o_jc, 1);
    check_eq("en0_drain_cyc", o_dc, 1);
    check_eq("en0_busy_low",  o_bl, 2);
    check_eq("en0_fid",       32'(o_fid), 0);

    run_case(JOIN_NONE, 4'b0011, 1'b0, 5, 8, -1, -1, -1);
    check_eq("none_join_cyc",  o_jc, 1);
    check_eq("none_elapsed",   32'(o_el), 0);
    check_eq("none_drain_cyc", o_dc, 9);
    check_eq("none_busy_low",  o_bl, 10);
    check_eq("none_el_hold",   32'(o_fe), 0);

    run_case(JOIN_ALL, 4'b0001, 1'b0, 5, -1, -1, 3, 2);
    check_eq("stray_join_cyc", o_jc, 6);
    check_eq("stray_fid",      32'(o_fid), 0);
    check_eq("stray_mask",     32'(o_fm), 4'b0001);
    check_eq("stray_elapsed",  32'(o_el), 5);
    check_eq("stray_busy_low", o_bl, 7);

    run_case(JOIN_ANY, 4'b0111, 1'b1, -1, 11, 10, -1, -1);
    check_eq("coinc_join_cyc", o_jc, 11);
    check_eq("coinc_kill",     32'(o_kv), 4'b0001);
    check_eq("coinc_mask",     32'(o_fm), 4'b0110);

    run_case(JOIN_ANY, 4'b0011, 1'b0, 5, 5, -1, -1, -1);
    check_eq("simul_join_cyc", o_jc, 6);
    check_eq("simul_njoin",    o_njoin, 1);
    check_eq("simul_ndrain",   o_ndrain, 1);
    check_eq("simul_mask",     32'(o_fm), 4'b0011);

    // Mid-run reset on the cycle an ANY+kill join would otherwise fire.
    bus.start = 1'b1; bus.mode = JOIN_ANY; bus.ch_en = 4'b0111; bus.kill_on_join = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus.ch_done = 4'b0010;
    @(posedge clk); #1;
    bus.ch_done = '0;
    rst = 1'b1;
    #1;
    check_eq("mrst_join_now", 32'(bus.join_done), 0);
    check_eq("mrst_kill_now", 32'(bus.ch_kill),   0);
    check_eq("mrst_go_now",   32'(bus.ch_go),     0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("mrst_busy", 32'(bus.busy),      0);
    check_eq("mrst_go",   32'(bus.ch_go),     0);
    check_eq("mrst_mask", 32'(bus.done_mask), 0);
    check_eq("mrst_elap", 32'(bus.elapsed),   0);
    check_eq("mrst_fid",  32'(bus.first_id),  0);
    check_eq("mrst_join", 32'(bus.join_done), 0);

    run_case(JOIN_ALL, 4'b0001, 1'b0, 3, -1, -1, -1, -1);
    check_eq("post_join_cyc",  o_jc, 4);
    check_eq("post_drain_cyc", o_dc, 4);
    check_eq("post_elapsed",   32'(o_el), 3);
    check_eq("post_nkill",     o_nkill, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
